// File: rtl/ram_bist_pkg.sv
// rtl/ram_bist_pkg.sv - shared types, LFSR constants and step function for the RAM BIST
package ram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Fibonacci step for x^16+x^14+x^13+x^11+1, shifting left
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ram_bist_expect_pipe.sv
// rtl/ram_bist_expect_pipe.sv - LAT-deep {valid, addr, data} expect shift register
module ram_bist_expect_pipe #(
  parameter int AW  = 4,
  parameter int DW  = 16,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data
);

  logic [LAT-1:0] vld;
  logic [AW-1:0]  adr [LAT];
  logic [DW-1:0]  dat [LAT];

  always_ff @(posedge clk) begin
    if (clr) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = LAT - 1; i > 0; i--) vld[i] <= vld[i-1];
    end
  end

  // Payload needs no clear; it is only observed behind its valid bit
  always_ff @(posedge clk) begin
    adr[0] <= in_addr;
    dat[0] <= in_data;
    for (int i = LAT - 1; i > 0; i--) begin
      adr[i] <= adr[i-1];
      dat[i] <= dat[i-1];
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_addr  = adr[LAT-1];
  assign out_data  = dat[LAT-1];

endmodule

// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - LFSR write/read-back self-test initiator for one pipelined RAM port
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int          AW     = 4,
  parameter int          DW     = 16,
  parameter int          RD_LAT = 2,
  parameter logic [15:0] SEED   = DEFAULT_SEED,
  parameter int          ERR_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ram_en,
  output logic             ram_we,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_di,
  input  logic [DW-1:0]    ram_dout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [AW-1:0]    first_err_addr
);

  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic [2:0]    DRAIN_END = 3'(RD_LAT - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] addr;
  logic [15:0]   lfsr;
  logic [2:0]    drain_cnt;
  logic          err_seen;
  logic [DW-1:0] di_hold;
  logic          accept;

  logic          exp_valid;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic          mismatch;

  ram_bist_expect_pipe #(.AW(AW), .DW(DW), .LAT(RD_LAT)) u_expect (
    .clk       (clk),
    .clr       (rst),
    .in_valid  (state == ST_READ),
    .in_addr   (addr),
    .in_data   (lfsr[DW-1:0]),
    .out_valid (exp_valid),
    .out_addr  (exp_addr),
    .out_data  (exp_data)
  );

  assign accept   = start && (state == ST_IDLE || state == ST_DONE);
  assign mismatch = exp_valid && (ram_dout != exp_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      addr           <= '0;
      lfsr           <= SEED;
      drain_cnt      <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      err_seen       <= 1'b0;
      di_hold        <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_WRITE: begin
          di_hold <= lfsr[DW-1:0];
          addr    <= addr + 1'b1;
          lfsr    <= (addr == LAST_ADDR) ? SEED : lfsr_next(lfsr);
        end
        ST_READ: begin
          addr      <= addr + 1'b1;
          lfsr      <= lfsr_next(lfsr);
          drain_cnt <= '0;
        end
        ST_DRAIN: drain_cnt <= drain_cnt + 1'b1;
        default: ;
      endcase
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (!err_seen) begin
          first_err_addr <= exp_addr;
          err_seen       <= 1'b1;
        end
      end
      if (accept) begin
        addr           <= '0;
        lfsr           <= SEED;
        err_count      <= '0;
        first_err_addr <= '0;
        err_seen       <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_WRITE;
      ST_WRITE: if (addr == LAST_ADDR) state_nxt = ST_READ;
      ST_READ:  if (addr == LAST_ADDR) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == DRAIN_END) state_nxt = ST_DONE;
      ST_DONE:  if (start) state_nxt = ST_WRITE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_en   = (state == ST_WRITE) || (state == ST_READ);
    ram_we   = (state == ST_WRITE);
    ram_addr = addr;
    ram_di   = (state == ST_WRITE) ? lfsr[DW-1:0] : di_hold;
    busy     = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
    done     = (state == ST_DONE);
    pass     = (state == ST_DONE) && (err_count == '0);
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb/tb_ram_bist_ctrl.sv - scoreboard bench for ram_bist_ctrl against behavioural RAM models
module tb_ram_bist_ctrl;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [3:0]  addr;
    logic [15:0] di;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err;
    logic [3:0]  fea;
  } obs_t;

  typedef struct {
    int          inst;
    int          ecnt;
    logic        pass;
    logic [15:0] err;
    logic [3:0]  fea;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start [4];
  logic [15:0] dout [4];
  logic [2:0]  err3;
  obs_t        o0, o1, o2, o3;
  obs_t        obs [4];

  int          ecount = 0;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          t0     = 0;
  exp_t        sb [$];

  logic [15:0] mem  [4][16];
  logic [15:0] rp   [4][4];
  int          lat  [4];
  int          mode [4];
  logic        done_q [4];
  exp_t        e_pop;

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  ram_bist_ctrl #(.AW(4), .DW(16), .RD_LAT(2), .SEED(16'hACE1), .ERR_W(16)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .ram_en(o0.en), .ram_we(o0.we),
    .ram_addr(o0.addr), .ram_di(o0.di), .ram_dout(dout[0]), .busy(o0.busy),
    .done(o0.done), .pass(o0.pass), .err_count(o0.err), .first_err_addr(o0.fea));

  ram_bist_ctrl #(.AW(4), .DW(16), .RD_LAT(2), .SEED(16'hACE1), .ERR_W(3)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .ram_en(o1.en), .ram_we(o1.we),
    .ram_addr(o1.addr), .ram_di(o1.di), .ram_dout(dout[1]), .busy(o1.busy),
    .done(o1.done), .pass(o1.pass), .err_count(err3), .first_err_addr(o1.fea));
  assign o1.err = {13'd0, err3};

  ram_bist_ctrl #(.AW(4), .DW(16), .RD_LAT(1), .SEED(16'hACE1), .ERR_W(16)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .ram_en(o2.en), .ram_we(o2.we),
    .ram_addr(o2.addr), .ram_di(o2.di), .ram_dout(dout[2]), .busy(o2.busy),
    .done(o2.done), .pass(o2.pass), .err_count(o2.err), .first_err_addr(o2.fea));

  ram_bist_ctrl #(.AW(4), .DW(16), .RD_LAT(4), .SEED(16'hACE1), .ERR_W(16)) u3 (
    .clk(clk), .rst(rst), .start(start[3]), .ram_en(o3.en), .ram_we(o3.we),
    .ram_addr(o3.addr), .ram_di(o3.di), .ram_dout(dout[3]), .busy(o3.busy),
    .done(o3.done), .pass(o3.pass), .err_count(o3.err), .first_err_addr(o3.fea));

  always_comb begin
    obs[0] = o0;
    obs[1] = o1;
    obs[2] = o2;
    obs[3] = o3;
  end

  // RAM model: read-first, mode 1 inverts address 5, mode 2 inverts every word
  function automatic logic [15:0] model_rd(int i);
    logic [15:0] d;
    d = mem[i][obs[i].addr];
    if (mode[i] == 2 || (mode[i] == 1 && obs[i].addr == 4'd5)) d = ~d;
    return d;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int k = 3; k > 0; k--) rp[i][k] <= rp[i][k-1];
      rp[i][0] <= obs[i].en ? model_rd(i) : 16'h0000;
      if (obs[i].en && obs[i].we) mem[i][obs[i].addr] <= obs[i].di;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_dout
    assign dout[g] = rp[g][lat[g]-1];
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rising done is matched against the oldest expected result
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (obs[i].done && !done_q[i]) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: inst %0d at count %0d, expected none", i, ecount);
        end else begin
          e_pop = sb.pop_front();
          check("done_inst", i, e_pop.inst);
          check("done_cycle", ecount, e_pop.ecnt);
          check("pass", {31'd0, obs[i].pass}, {31'd0, e_pop.pass});
          check("err_count", {16'd0, obs[i].err}, {16'd0, e_pop.err});
          check("first_err_addr", {28'd0, obs[i].fea}, {28'd0, e_pop.fea});
        end
      end
      done_q[i] <= obs[i].done;
    end
  end

  task automatic kick(int i, bit push, int done_cyc, logic p, logic [15:0] er, logic [3:0] fa);
    exp_t e;
    @(negedge clk);
    start[i] = 1'b1;
    t0 = ecount + 1;
    if (push) begin
      e = '{i, t0 + done_cyc - 1, p, er, fa};
      sb.push_back(e);
    end
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_cyc(int k);
    while (ecount < t0 + k - 1) @(negedge clk);
  endtask

  task automatic pulse_start(int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(int i);
    int n = 0;
    while (!obs[i].done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", n < 200, 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      start[i]  = 1'b0;
      mode[i]   = 0;
      done_q[i] = 1'b0;
    end
    lat[0] = 2; lat[1] = 2; lat[2] = 1; lat[3] = 4;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_port", {obs[0].en, obs[0].we, obs[0].addr, obs[0].di}, 32'd0);
    check("rst_status", {obs[0].busy, obs[0].done, obs[0].pass, obs[0].err, obs[0].fea}, 32'd0);
    rst = 1'b0;

    // Ideal RAM: port sequence and completion
    kick(0, 1, 35, 1'b1, 16'd0, 4'd0);
    check("w0_port", {obs[0].en, obs[0].we, obs[0].addr}, {1'b1, 1'b1, 4'd0});
    check("w0_di", obs[0].di, 16'hACE1);
    wait_cyc(2);
    check("w1_di", obs[0].di, 16'h59C3);
    wait_cyc(16);
    check("w15_port", {obs[0].en, obs[0].we, obs[0].addr}, {1'b1, 1'b1, 4'd15});
    wait_cyc(17);
    check("r0_port", {obs[0].en, obs[0].we, obs[0].addr}, {1'b1, 1'b0, 4'd0});
    wait_cyc(33);
    check("drain_port", {obs[0].en, obs[0].we, obs[0].busy}, {1'b0, 1'b0, 1'b1});
    wait_done(0);

    // Corrupt address 5; start from DONE
    mode[0] = 1;
    kick(0, 1, 35, 1'b0, 16'd1, 4'd5);
    check("restart_done_low", obs[0].done, 0);
    wait_done(0);

    // Ideal rerun with starts while busy
    mode[0] = 0;
    kick(0, 1, 35, 1'b1, 16'd0, 4'd0);
    check("restart_err_clr", obs[0].err, 0);
    wait_cyc(5);
    pulse_start(0);
    wait_cyc(25);
    pulse_start(0);
    wait_done(0);

    // RAM one cycle slower than RD_LAT: every word compares against its predecessor
    lat[0] = 3;
    kick(0, 1, 35, 1'b0, 16'd16, 4'd0);
    wait_done(0);
    lat[0] = 2;

    // All-wrong RAM with 3-bit counter saturates
    mode[1] = 2;
    kick(1, 1, 35, 1'b0, 16'd7, 4'd0);
    wait_done(1);

    // Reset mid-READ, then a clean run
    mode[0] = 2;
    kick(0, 0, 0, 1'b0, 16'd0, 4'd0);
    wait_cyc(20);
    check("pre_rst_err", obs[0].err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post_rst", {obs[0].en, obs[0].busy, obs[0].done, obs[0].err}, 32'd0);
    mode[0] = 0;
    kick(0, 1, 35, 1'b1, 16'd0, 4'd0);
    wait_done(0);

    // Other read latencies
    kick(2, 1, 34, 1'b1, 16'd0, 4'd0);
    wait_done(2);
    kick(3, 1, 37, 1'b1, 16'd0, 4'd0);
    wait_done(3);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
